// File: rtl/full_adder_structural.sv
// Structural ripple-carry adder built only from xor/and/or gate primitives.
// The sum and carry_out outputs are combinational. sum_q and carry_out_q are
// registered copies for pipelined consumers.
module full_adder_structural #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             en,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_out_q
);

    localparam int unsigned MAX_WIDTH = 64;

    // Reject out-of-range widths at elaboration time.
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("full_adder_structural: WIDTH must be in 1..64");
    end

    // One full-adder cell per bit: half adder (a,b), half adder (p,cin), then OR.
    // Each cell keeps its own carry nets, so the chain has no combinational
    // loop through a shared vector.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        wire cin_cell;
        wire cout_cell;
        wire p;
        wire g;
        wire t;

        if (i == 0) begin : g_first
            assign cin_cell = carry_in;
        end else begin : g_chain
            assign cin_cell = g_bit[i-1].cout_cell;
        end

        // First half adder: propagate and generate.
        xor u_ha0_x (p, a[i], b[i]);
        and u_ha0_a (g, a[i], b[i]);

        // Second half adder: sum bit and propagated carry term.
        xor u_ha1_x (sum[i], p, cin_cell);
        and u_ha1_a (t, p, cin_cell);

        // Carry merge.
        or  u_cor   (cout_cell, g, t);
    end

    assign carry_out = g_bit[WIDTH-1].cout_cell;

    // Registered copy of the result, captured when en is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            carry_out_q <= 1'b0;
        end else if (en) begin
            sum_q       <= sum;
            carry_out_q <= carry_out;
        end
    end

endmodule

// File: tb/tb_full_adder_structural.sv
// Directed and random checks of full_adder_structural at WIDTH=1 and WIDTH=8.
module tb_full_adder_structural;

    logic       clk;
    logic       rst_n;

    logic       a1;
    logic       b1;
    logic       cin1;
    logic       en1;
    logic       sum1;
    logic       cout1;
    logic       sum1_q;
    logic       cout1_q;

    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       en8;
    logic [7:0] sum8;
    logic       cout8;
    logic [7:0] sum8_q;
    logic       cout8_q;

    int checks = 0;
    int errors = 0;

    full_adder_structural #(.WIDTH(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a1),
        .b           (b1),
        .carry_in    (cin1),
        .en          (en1),
        .sum         (sum1),
        .carry_out   (cout1),
        .sum_q       (sum1_q),
        .carry_out_q (cout1_q)
    );

    full_adder_structural #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a8),
        .b           (b8),
        .carry_in    (cin8),
        .en          (en8),
        .sum         (sum8),
        .carry_out   (cout8),
        .sum_q       (sum8_q),
        .carry_out_q (cout8_q)
    );

    // 10-unit clock; the first rising edge is at t=5.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it if the values differ.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Truth table rows {a,b,cin} -> {cout,sum}, hand-computed.
    logic [1:0] tt_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    // Directed 8-bit vectors {a, b, cin, exp_sum, exp_cout}, hand-computed.
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec8_t;

    vec8_t vecs [6] = '{
        '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1},
        '{8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0},
        '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1},
        '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1},
        '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0},
        '{8'h0F, 8'h01, 1'b1, 8'h11, 1'b0}
    };

    logic [8:0] model;
    logic [7:0] exp_sq;
    logic       exp_cq;
    logic [2:0] row;

    initial begin
        rst_n = 1'b0;
        en1   = 1'b0;
        en8   = 1'b0;
        a1    = 1'b0;
        b1    = 1'b0;
        cin1  = 1'b0;
        a8    = 8'h00;
        b8    = 8'h00;
        cin8  = 1'b0;

        // WIDTH=1 truth table, one row per time unit; no clock dependence.
        for (int i = 0; i < 8; i++) begin
            row  = 3'(i);
            a1   = row[2];
            b1   = row[1];
            cin1 = row[0];
            #1;
            check($sformatf("tt%0d_sum", i), 64'(sum1), 64'(tt_exp[i][0]));
            check($sformatf("tt%0d_cout", i), 64'(cout1), 64'(tt_exp[i][1]));
        end

        // Registered outputs in reset.
        check("rst_sum1_q", 64'(sum1_q), 64'd0);
        check("rst_cout1_q", 64'(cout1_q), 64'd0);
        check("rst_sum8_q", 64'(sum8_q), 64'd0);
        check("rst_cout8_q", 64'(cout8_q), 64'd0);

        // WIDTH=8 directed vectors including the full-ripple cases.
        for (int i = 0; i < 6; i++) begin
            a8   = vecs[i].a;
            b8   = vecs[i].b;
            cin8 = vecs[i].cin;
            #1;
            check($sformatf("v%0d_sum8", i), 64'(sum8), 64'(vecs[i].s));
            check($sformatf("v%0d_cout8", i), 64'(cout8), 64'(vecs[i].co));
        end

        // Release reset and capture 1+1+1 on one enabled edge.
        @(negedge clk);
        rst_n = 1'b1;
        a1    = 1'b1;
        b1    = 1'b1;
        cin1  = 1'b1;
        en1   = 1'b1;
        #1;
        check("pre_cap_sum1_q", 64'(sum1_q), 64'd0);
        @(posedge clk);
        #1;
        check("cap_sum1_q", 64'(sum1_q), 64'd1);
        check("cap_cout1_q", 64'(cout1_q), 64'd1);

        // Disabled: change inputs, registered outputs hold.
        @(negedge clk);
        en1  = 1'b0;
        a1   = 1'b0;
        b1   = 1'b0;
        cin1 = 1'b0;
        @(posedge clk);
        #1;
        check("hold_sum1_q", 64'(sum1_q), 64'd1);
        check("hold_cout1_q", 64'(cout1_q), 64'd1);
        check("hold_sum1", 64'(sum1), 64'd0);

        // Asynchronous reset between edges; combinational path keeps tracking.
        #1;
        rst_n = 1'b0;
        a1    = 1'b1;
        #1;
        check("async_rst_sum1_q", 64'(sum1_q), 64'd0);
        check("async_rst_cout1_q", 64'(cout1_q), 64'd0);
        check("async_rst_sum1", 64'(sum1), 64'd1);
        check("async_rst_cout1", 64'(cout1), 64'd0);

        // Enable held high during reset must not capture.
        en1 = 1'b1;
        @(posedge clk);
        #1;
        check("rst_en_sum1_q", 64'(sum1_q), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        en1   = 1'b0;

        // WIDTH=8 random vectors against an arithmetic model.
        exp_sq = 8'h00;
        exp_cq = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            cin8 = 1'($urandom);
            en8  = 1'($urandom);
            model = {1'b0, a8} + {1'b0, b8} + 9'(cin8);
            #1;
            check("rnd_sum8", 64'(sum8), 64'(model[7:0]));
            check("rnd_cout8", 64'(cout8), 64'(model[8]));
            if (en8) begin
                exp_sq = model[7:0];
                exp_cq = model[8];
            end
            @(posedge clk);
            #1;
            check("rnd_sum8_q", 64'(sum8_q), 64'(exp_sq));
            check("rnd_cout8_q", 64'(cout8_q), 64'(exp_cq));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
